seq_mem_lane_rf: RTL
====================

# seq_mem_lane_rf

Parametrised multi-read-port register file with per-lane write enables and registered, write-first read ports. It generalises the 8x8b nibble-write register file to arbitrary depth, lane width, lane count and number of read ports. It adds a 1-cycle synchronous read with lane-granular same-cycle write bypass and an asynchronous clear of all contents. It serves as a storage primitive in datapaths needing partial-word updates, such as byte-enabled scratchpads and tag/state arrays.

## Interface
- DEPTH, 8, number of entries; DEPTH >= 2; need not be a power of two
- LANE_W, 4, bits per write lane
- NLANES, 2, lanes per word; word width W = NLANES*LANE_W
- NRD, 2, number of read ports, >= 1
- Derived: AW = $clog2(DEPTH)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_en  in  NRD  per-port read request
- rd_addr  in  NRD*AW  port i uses bits [i*AW +: AW]
- rd_data  out  NRD*W  port i uses bits [i*W +: W]
- rd_val  out  NRD  rd_data for port i updated this cycle
- wr_lane_en  in  NLANES  per-lane write enable; all-zero means no write
- wr_addr  in  AW  write entry
- wr_data  in  W  lane k uses bits [k*LANE_W +: LANE_W]

## Operation
- Storage: DEPTH x W flops. reset_n low asynchronously clears every entry, every rd_data and every rd_val to 0.
- Write: on a rising edge with reset_n high, for each k where wr_lane_en[k]=1, lane k of mem[wr_addr] takes lane k of wr_data. Lanes with enable 0 keep their value.
- Write to wr_addr >= DEPTH is dropped. No entry changes.
- Read request: on a rising edge with rd_en[i]=1, port i captures mem[rd_addr_i] into rd_data_i and sets rd_val[i]=1.
- Out-of-range rd_addr_i (>= DEPTH) captures all zeros and still sets rd_val[i]=1.
- No request: with rd_en[i]=0, rd_data_i holds its last value and rd_val[i]=0.
- Write-first bypass: if the write and a read hit the same in-range address on the same edge, the captured word is merged per lane.
  - Lane k comes from wr_data where wr_lane_en[k]=1.
  - Lane k comes from the pre-write mem contents otherwise.
- Multiple read ports may read the same or different addresses in the same cycle. Each port applies the bypass independently.
- No structural hazards. There is no stall or backpressure: every request completes.

## Timing
- Read latency: exactly 1 cycle. A request at edge N gives data and rd_val at edge N, visible in cycle N+1.
- Write latency: the entry updates at edge N. A read requested at edge N already returns the new lanes via bypass.
- rd_data and rd_val are pure flop outputs. There is no combinational path from any input to any output.
- Reset asserted mid-operation: all state goes to 0 immediately. A request or write in flight at the deasserting edge is lost.
- First edge after reset_n rises behaves normally. Reads return 0 except for bypassed lanes.
- Back-to-back read requests on one port are allowed every cycle.

## Structure
- Package seq_mem_lane_rf_pkg holds:
  - default parameter constants
  - a lane-merge function (old word, new word, lane mask -> merged word), shared by the write path and the bypass
- One sub-module, seq_mem_lane_rf_rdport, is instantiated NRD times.
  - Takes rd_en, rd_addr, the selected mem word, and the write bypass signals (wr_lane_en, wr_addr, wr_data).
  - Owns the rd_data/rd_val flops.
- The top level owns the storage array and the write decode.

## Test plan
Defaults throughout (DEPTH=8, LANE_W=4, NLANES=2, NRD=2).
1. Reset check: assert reset_n=0 mid-run, then read all 8 addresses on port 0 -> every rd_data 0; rd_val=0 during reset.
2. Partial write:
   - write addr 3 data 0xAB lanes 2'b11 -> word is 0xAB
   - write addr 3 data 0x5C lanes 2'b01 -> read of addr 3 returns 0xAC one cycle later
   - write addr 3 data 0x5C lanes 2'b10 -> read of addr 3 returns 0x5C
3. Bypass: mem[5]=0x12. On one edge, write addr 5 data 0xEF lanes 2'b10 and read addr 5 on both ports -> both return 0xE2 next cycle. A following read returns 0xE2.
4. Dual port: mem[1]=0x11 and mem[6]=0x66. Port 0 reads 1, port 1 reads 6 on the same edge -> 0x11 and 0x66, both rd_val=1.
5. Hold and out-of-range: after a read returns 0x66, drop rd_en for 3 cycles -> rd_data stays 0x66 and rd_val=0.
6. Random regression: random lane masks, addresses and rd_en on all ports for 10k cycles against a lane-merging scoreboard, including same-address write/read collisions every cycle.

Source files
------------

// File: rtl/seq_mem_lane_rf_pkg.sv
// seq_mem_lane_rf_pkg
//   Shared definitions for the lane-enabled register file:
//   - DEF_* : default geometry (depth, lane width, lane count, read ports)
//   - MAX_W / MAX_LANES : widest word / most lanes lane_merge() accepts
//   - lane_merge() : per-lane select between an old and a new word, used by
//     both the storage write path and the read-port write bypass so the two
//     can never disagree on lane boundaries.
package seq_mem_lane_rf_pkg;

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_LANE_W = 4;
  localparam int DEF_NLANES = 2;
  localparam int DEF_NRD    = 2;

  localparam int MAX_W     = 1024;
  localparam int MAX_LANES = 128;
  localparam int LANE_IW   = $clog2(MAX_LANES);

  // Callers zero-extend into MAX_W and size-cast the result back to their own
  // word width, which lets one function serve every instance geometry.
  function automatic logic [MAX_W-1:0] lane_merge(
    input logic [MAX_W-1:0]     old_word,
    input logic [MAX_W-1:0]     new_word,
    input logic [MAX_LANES-1:0] lane_mask,
    input int                   lane_w,
    input int                   nlanes
  );
    logic [MAX_W-1:0]   merged;
    logic [LANE_IW-1:0] lane_idx;
    merged = old_word;
    for (int b = 0; b < MAX_W; b++) begin
      lane_idx = LANE_IW'(b / lane_w);
      if ((b < lane_w * nlanes) && lane_mask[lane_idx]) begin
        merged[b] = new_word[b];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/seq_mem_lane_rf_rdport.sv
// seq_mem_lane_rf_rdport
//   One registered, write-first read port.
//   clk, reset_n      : clock / async active-low clear of rd_data and rd_val
//   rd_en, rd_addr    : read request for this port
//   mem_word          : storage word currently selected by rd_addr
//   wr_lane_en, wr_addr, wr_data : the write happening on the same edge
//   rd_data, rd_val   : captured word and "updated this cycle" flag
module seq_mem_lane_rf_rdport
  import seq_mem_lane_rf_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int LANE_W = DEF_LANE_W,
  parameter int NLANES = DEF_NLANES,
  parameter int AW     = $clog2(DEF_DEPTH),
  parameter int W      = DEF_LANE_W * DEF_NLANES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  input  logic [W-1:0]      mem_word,
  input  logic [NLANES-1:0] wr_lane_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [W-1:0]      wr_data,
  output logic [W-1:0]      rd_data,
  output logic              rd_val
);

  logic         rd_in_range;
  logic         wr_hit;
  logic [W-1:0] captured;

  // Out-of-range reads return zero and never see the bypass; in-range reads
  // that collide with this edge's write pick up the written lanes.
  always_comb begin
    rd_in_range = {1'b0, rd_addr} < (AW+1)'(DEPTH);
    wr_hit      = rd_in_range && (rd_addr == wr_addr);
    if (!rd_in_range) begin
      captured = '0;
    end else if (wr_hit) begin
      captured = W'(lane_merge(MAX_W'(mem_word), MAX_W'(wr_data),
                               MAX_LANES'(wr_lane_en), LANE_W, NLANES));
    end else begin
      captured = mem_word;
    end
  end

  // rd_data holds between requests; rd_val only marks the cycle after one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
      rd_val  <= 1'b0;
    end else begin
      rd_val <= rd_en;
      if (rd_en) begin
        rd_data <= captured;
      end
    end
  end

endmodule

// File: rtl/seq_mem_lane_rf.sv
// seq_mem_lane_rf
//   DEPTH x (NLANES*LANE_W) register file, per-lane write enables, NRD
//   registered write-first read ports, asynchronous clear of all state.
//   clk, reset_n : clock / async active-low clear
//   rd_en[i], rd_addr[i*AW +: AW] -> rd_data[i*W +: W], rd_val[i] (1 cycle)
//   wr_lane_en, wr_addr, wr_data  : lane-masked write, all-zero mask = none
module seq_mem_lane_rf
  import seq_mem_lane_rf_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int LANE_W = DEF_LANE_W,
  parameter int NLANES = DEF_NLANES,
  parameter int NRD    = DEF_NRD,
  localparam int AW    = $clog2(DEPTH),
  localparam int W     = NLANES * LANE_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*W-1:0]  rd_data,
  output logic [NRD-1:0]    rd_val,
  input  logic [NLANES-1:0] wr_lane_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [W-1:0]      wr_data
);

  logic [W-1:0] mem     [DEPTH];
  logic [W-1:0] rd_word [NRD];
  logic         wr_en;

  assign wr_en = |wr_lane_en;

  // Decoding by comparison against every entry index means an address at or
  // beyond DEPTH (possible when DEPTH is not a power of two) matches nothing,
  // so such writes drop without a separate range check.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem[e] <= '0;
      end
    end else if (wr_en) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (wr_addr == AW'(e)) begin
          mem[e] <= W'(lane_merge(MAX_W'(mem[e]), MAX_W'(wr_data),
                                  MAX_LANES'(wr_lane_en), LANE_W, NLANES));
        end
      end
    end
  end

  // Same decode style for the read mux; unmatched addresses yield zero.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rd_word[p] = '0;
      for (int e = 0; e < DEPTH; e++) begin
        if (rd_addr[p*AW +: AW] == AW'(e)) begin
          rd_word[p] = mem[e];
        end
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rdport
    seq_mem_lane_rf_rdport #(
      .DEPTH  (DEPTH),
      .LANE_W (LANE_W),
      .NLANES (NLANES),
      .AW     (AW),
      .W      (W)
    ) u_rdport (
      .clk        (clk),
      .reset_n    (reset_n),
      .rd_en      (rd_en[i]),
      .rd_addr    (rd_addr[i*AW +: AW]),
      .mem_word   (rd_word[i]),
      .wr_lane_en (wr_lane_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_data    (rd_data[i*W +: W]),
      .rd_val     (rd_val[i])
    );
  end

endmodule
